dht_sensor_responder: RTL and testbench
=======================================

Name: dht_sensor_responder

Overview:
Sensor-side end of the single-wire DHT11-style query bus. It detects the FPGA host's start pulse, then drives the ACK preamble and a 40-bit frame (hum_int, hum_dec, temp_int, temp_dec, checksum) with open-drain signalling. It sits opposite the FPGA-side tri-state pin driver. It serves as an on-board sensor emulator for loopback bring-up and as the bench model of the sensor.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency; one µs tick = CLK_FREQ_HZ/1_000_000 cycles (must divide exactly).
START_MIN_US, 18000, minimum host-low duration accepted as a start request.
RESP_DELAY_US, 30, wait after host release before the ACK is driven.

Ports:
clock  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset.
line_in  input  1  sampled bus level; asynchronous, 2-flop synchronised internally.
line_drive_low  output  1  1 = pull bus low; 0 = release (external pull-up).
hum_int, hum_dec, temp_int, temp_dec  input  8 each  measurement bytes to report.
busy  output  1  high from accepted start until frame end.
frame_done  output  1  one-cycle pulse after the END_LOW phase completes.
bus_error  output  1  one-cycle pulse on detected bus conflict.

Behaviour:
- Reset (reset=0 at a clock edge): line_drive_low=0, busy=0, frame_done=0, bus_error=0, state=IDLE, counters=0, sync flops=1.
- All durations are counted in µs ticks from an internal prescaler. The prescaler restarts on every state change, so each phase is exact to ±1 clock.
- IDLE: on synced line=0, go to HOST_LOW with us_cnt=0.
- HOST_LOW: us_cnt increments per tick and saturates at START_MIN_US.
  - On line=1 with us_cnt>=START_MIN_US: go to RESP_WAIT, snapshot the four bytes into the frame register, set checksum = (sum of the four bytes) mod 256, busy=1.
  - On line=1 with a shorter low: return to IDLE silently.
- RESP_WAIT: RESP_DELAY_US released -> ACK_LOW.
- ACK_LOW: drive low 80 µs -> ACK_HIGH.
- ACK_HIGH: release 80 µs -> BIT_LOW with bit_idx=39.
- BIT_LOW: drive low 50 µs -> BIT_HIGH.
- BIT_HIGH: release for 26 µs (bit=0) or 70 µs (bit=1).
  - If bit_idx=0: go to END_LOW.
  - Otherwise: decrement bit_idx and go to BIT_LOW.
- Bit order: MSB first; hum_int first, checksum last.
- END_LOW: drive low 50 µs, then release; frame_done=1 for one cycle, busy=0, go to IDLE.
- Conflict rule: in RESP_WAIT, ACK_HIGH or BIT_HIGH, if synced line=0 for 2 consecutive ticks while not driving, then bus_error pulses, the bus is released, busy=0, go to IDLE.
  - The first tick after any release is ignored, to allow pull-up rise time.
- Measurement inputs may change at any time. Only the snapshot taken at start acceptance is transmitted, so mid-frame changes never affect the frame in flight.
- Reset mid-frame releases the line on the same edge; no frame_done is generated.
- Latency: first ACK_LOW drive edge occurs RESP_DELAY_US µs plus 3 clocks (2 sync, 1 FSM) after the host's rising edge.
- Total frame time after RESP_WAIT: 160 + Σ(50 + 26|70) + 50 µs.

Optional Feature:
SENSOR_FAULT_INJECT_EN.
- Defined: adds input port fault_inject (1 bit), sampled at snapshot. If 1, the transmitted checksum has its LSB inverted, so host CRC-error handling can be exercised.
- Undefined: the port does not exist and the checksum is always correct.

Decomposition:
- Package dht_pkg holds:
  - the state enum (IDLE, HOST_LOW, RESP_WAIT, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW);
  - timing constants in µs: ACK_LOW_US=80, ACK_HIGH_US=80, BIT_LOW_US=50, BIT0_HIGH_US=26, BIT1_HIGH_US=70, END_LOW_US=50;
  - FRAME_BITS=40.
- One sub-module, dht_us_tick: prescaler with a synchronous clear input, producing a one-clock tick every CLK_FREQ_HZ/1e6 cycles.

Test Plan:
Bench settings: CLK_FREQ_HZ=1_000_000, START_MIN_US=1000; host model with pull-up.
- Nominal frame: inputs 0x37,0x00,0x19,0x05, host low 1200 µs then release → decoded frame 37 00 19 05 55; frame_done once; ACK low/high = 80/80 µs ±1.
- Short start: host low 999 µs → no drive, busy stays 0. A second pulse of 1000 µs → response starts.
- Checksum wrap: inputs FF,FF,FF,FF → checksum byte 0xFC.
- Snapshot: change inputs to 0x00 at bit 10 of a frame → the remaining bits still match the original bytes.
- Bus conflict: host pulls low 20 µs into ACK_HIGH → bus_error pulse, line released within 3 cycles, busy=0, next valid start serviced normally.
- Reset mid-BIT_LOW: reset=0 for one cycle → line_drive_low=0 on that edge, no frame_done; with SENSOR_FAULT_INJECT_EN and fault_inject=1, the nominal frame's checksum reads 0x54.

Source files
------------

// File: rtl/dht_pkg.sv
// Shared types, phase timings and checksum helper for the DHT11-style sensor responder.
package dht_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOST_LOW,
        RESP_WAIT,
        ACK_LOW,
        ACK_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } state_t;

    localparam int ACK_LOW_US   = 80;
    localparam int ACK_HIGH_US  = 80;
    localparam int BIT_LOW_US   = 50;
    localparam int BIT0_HIGH_US = 26;
    localparam int BIT1_HIGH_US = 70;
    localparam int END_LOW_US   = 50;
    localparam int FRAME_BITS   = 40;

    function automatic logic [7:0] frame_checksum(input logic [7:0] a, input logic [7:0] b,
                                                  input logic [7:0] c, input logic [7:0] d);
        logic [9:0] sum;
        sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        return sum[7:0];
    endfunction

endpackage

// File: rtl/dht_us_tick.sv
// Microsecond prescaler; a clear makes the cycle after a phase change count as
// the first cycle of the new microsecond, so phases line up with state entry.
module dht_us_tick #(
    parameter int DIV = 50
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_eff;

    assign cnt_eff = clear ? '0 : cnt;
    assign tick    = (cnt_eff == W'(DIV - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= tick ? '0 : cnt_eff + W'(1);
        end
    end

endmodule

// File: rtl/dht_sensor_responder.sv
// Sensor side of the single-wire DHT11 bus: detects the host start pulse, answers with
// ACK and a 40-bit frame. Optional SENSOR_FAULT_INJECT_EN adds a checksum-corrupting input.
module dht_sensor_responder
    import dht_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int START_MIN_US  = 18000,
    parameter int RESP_DELAY_US = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       line_in,
    output logic       line_drive_low,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
`ifdef SENSOR_FAULT_INJECT_EN
    input  logic       fault_inject,
`endif
    output logic       busy,
    output logic       frame_done,
    output logic       bus_error
);

    localparam int DIV    = CLK_FREQ_HZ / 1_000_000;
    localparam int US_MAX = (START_MIN_US > RESP_DELAY_US) ? START_MIN_US : RESP_DELAY_US;
    localparam int CNT_W  = $clog2(((US_MAX > 255) ? US_MAX : 255) + 1);
    localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_MIN_US);

    state_t                state;
    logic                  sync1;
    logic                  line_s;
    logic                  restart;
    logic                  tick;
    logic                  low_seen;
    logic [CNT_W-1:0]      us_cnt;
    logic [CNT_W-1:0]      phase_len;
    logic [5:0]            bit_idx;
    logic [FRAME_BITS-1:0] frame;
    logic [7:0]            cs_now;
    logic                  monitored;
    logic                  phase_end;
    logic                  host_long;
    logic                  conflict;

    dht_us_tick #(.DIV(DIV)) u_tick (
        .clock(clock),
        .reset(reset),
        .clear(restart),
        .tick (tick)
    );

`ifdef SENSOR_FAULT_INJECT_EN
    assign cs_now = frame_checksum(hum_int, hum_dec, temp_int, temp_dec) ^ {7'b0, fault_inject};
`else
    assign cs_now = frame_checksum(hum_int, hum_dec, temp_int, temp_dec);
`endif

    always_comb begin
        phase_len = START_CNT;
        case (state)
            RESP_WAIT: phase_len = CNT_W'(RESP_DELAY_US);
            ACK_LOW:   phase_len = CNT_W'(ACK_LOW_US);
            ACK_HIGH:  phase_len = CNT_W'(ACK_HIGH_US);
            BIT_LOW:   phase_len = CNT_W'(BIT_LOW_US);
            BIT_HIGH:  phase_len = frame[bit_idx] ? CNT_W'(BIT1_HIGH_US) : CNT_W'(BIT0_HIGH_US);
            END_LOW:   phase_len = CNT_W'(END_LOW_US);
            default:   phase_len = START_CNT;
        endcase
    end

    // The rising-edge tick itself counts toward the start length, so a pulse of
    // exactly START_MIN_US is accepted.
    assign monitored = (state == RESP_WAIT) || (state == ACK_HIGH) || (state == BIT_HIGH);
    assign phase_end = tick && (us_cnt == phase_len - CNT_W'(1));
    assign host_long = (us_cnt >= START_CNT) || (tick && (us_cnt == START_CNT - CNT_W'(1)));
    assign conflict  = monitored && tick && (us_cnt != '0) && low_seen && !line_s;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1          <= 1'b1;
            line_s         <= 1'b1;
            state          <= IDLE;
            us_cnt         <= '0;
            bit_idx        <= '0;
            frame          <= '0;
            restart        <= 1'b0;
            low_seen       <= 1'b0;
            line_drive_low <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            bus_error      <= 1'b0;
        end else begin
            sync1      <= line_in;
            line_s     <= sync1;
            restart    <= 1'b0;
            frame_done <= 1'b0;
            bus_error  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!line_s) begin
                        state   <= HOST_LOW;
                        us_cnt  <= '0;
                        restart <= 1'b1;
                    end
                end
                HOST_LOW: begin
                    if (line_s) begin
                        us_cnt  <= '0;
                        restart <= 1'b1;
                        if (host_long) begin
                            state <= RESP_WAIT;
                            frame <= {hum_int, hum_dec, temp_int, temp_dec, cs_now};
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (tick && (us_cnt < START_CNT)) begin
                        us_cnt <= us_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (conflict) begin
                        state          <= IDLE;
                        line_drive_low <= 1'b0;
                        busy           <= 1'b0;
                        bus_error      <= 1'b1;
                        us_cnt         <= '0;
                        low_seen       <= 1'b0;
                        restart        <= 1'b1;
                    end else if (phase_end) begin
                        us_cnt   <= '0;
                        low_seen <= 1'b0;
                        restart  <= 1'b1;
                        case (state)
                            RESP_WAIT: begin
                                state          <= ACK_LOW;
                                line_drive_low <= 1'b1;
                            end
                            ACK_LOW: begin
                                state          <= ACK_HIGH;
                                line_drive_low <= 1'b0;
                            end
                            ACK_HIGH: begin
                                state          <= BIT_LOW;
                                line_drive_low <= 1'b1;
                                bit_idx        <= 6'(FRAME_BITS - 1);
                            end
                            BIT_LOW: begin
                                state          <= BIT_HIGH;
                                line_drive_low <= 1'b0;
                            end
                            BIT_HIGH: begin
                                line_drive_low <= 1'b1;
                                if (bit_idx == '0) begin
                                    state <= END_LOW;
                                end else begin
                                    bit_idx <= bit_idx - 6'd1;
                                    state   <= BIT_LOW;
                                end
                            end
                            default: begin
                                state          <= IDLE;
                                line_drive_low <= 1'b0;
                                busy           <= 1'b0;
                                frame_done     <= 1'b1;
                            end
                        endcase
                    end else if (tick) begin
                        // The first tick of a released phase is skipped to let the pull-up recover.
                        us_cnt <= us_cnt + CNT_W'(1);
                        if (monitored && (us_cnt != '0)) begin
                            low_seen <= !line_s;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht_sensor_responder.sv
// Bench for dht_sensor_responder: host model with pull-up, bus decoder and frame scoreboard.
// Build with SENSOR_FAULT_INJECT_EN defined to also exercise the checksum fault input.
module tb_dht_sensor_responder;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       host_low = 1'b0;
    logic       line_drive_low;
    logic       busy;
    logic       frame_done;
    logic       bus_error;
    logic [7:0] hum_int = 8'h00;
    logic [7:0] hum_dec = 8'h00;
    logic [7:0] temp_int = 8'h00;
    logic [7:0] temp_dec = 8'h00;
`ifdef SENSOR_FAULT_INJECT_EN
    logic       fault_inject = 1'b0;
`endif
    logic       bus;

    assign bus = !(host_low || line_drive_low);

    always #5 clock = ~clock;

    dht_sensor_responder #(
        .CLK_FREQ_HZ  (1_000_000),
        .START_MIN_US (1000),
        .RESP_DELAY_US(30)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .line_in       (bus),
        .line_drive_low(line_drive_low),
        .hum_int       (hum_int),
        .hum_dec       (hum_dec),
        .temp_int      (temp_int),
        .temp_dec      (temp_dec),
`ifdef SENSOR_FAULT_INJECT_EN
        .fault_inject  (fault_inject),
`endif
        .busy          (busy),
        .frame_done    (frame_done),
        .bus_error     (bus_error)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [39:0] exp_q[$];

    int          rd_ptr = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          drive_cnt = 0;
    int          dst = 0;
    int          dec_bits = 0;
    logic [39:0] shreg = '0;
    int          run = 0;
    logic        line_prev = 1'b1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_vec++;
        if (actual != expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        n_vec++;
        if (actual < lo || actual > hi) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Monitor: measures bus run lengths, decodes ACK and bits, and scores each completed frame.
    always @(negedge clock) begin
        if (frame_done) done_cnt++;
        if (bus_error) err_cnt++;
        if (line_drive_low) drive_cnt++;
        if (bus != line_prev) begin
            if (!line_prev) begin
                if (dst == 0 && run >= 60 && run <= 100) begin
                    checkRange("ack_low_us", run, 79, 81);
                    dst = 1;
                end else if (dst == 1) begin
                    dst = 0;
                end else if (dst == 2 && (run < 45 || run > 55)) begin
                    dst = 0;
                end
            end else begin
                if (dst == 1) begin
                    if (run >= 60 && run <= 100) begin
                        checkRange("ack_high_us", run, 79, 81);
                        dst      = 2;
                        dec_bits = 0;
                        shreg    = '0;
                    end else begin
                        dst = 0;
                    end
                end else if (dst == 2) begin
                    if (run > 100) begin
                        dst = 0;
                    end else begin
                        shreg = {shreg[38:0], (run > 48)};
                        dec_bits++;
                        if (dec_bits == 40) begin
                            if (rd_ptr < exp_q.size())
                                checkOutput($sformatf("frame%0d", rd_ptr), shreg, exp_q[rd_ptr]);
                            rd_ptr++;
                            dst = 0;
                        end
                    end
                end
            end
            run = 1;
        end else begin
            run++;
        end
        line_prev = bus;
    end

    task automatic hostPulse(input int low_us);
        @(negedge clock);
        host_low = 1'b1;
        repeat (low_us) @(negedge clock);
        host_low = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                 input logic [7:0] d, input int low_us, input bit expect_frame,
                                 input logic [7:0] cs);
        int k;
        hum_int  = a;
        hum_dec  = b;
        temp_int = c;
        temp_dec = d;
        if (expect_frame) exp_q.push_back({a, b, c, d, cs});
        hostPulse(low_us);
        if (expect_frame) begin
            k = 0;
            while (!line_drive_low && k < 100) begin
                @(negedge clock);
                k++;
            end
            checkRange("ack_latency", k, 32, 34);
            checkOutput("busy_in_frame", busy, 1);
        end
    endtask

    task automatic waitDone(input string name);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < 12000) begin
            @(negedge clock);
            k++;
        end
        repeat (5) @(negedge clock);
        checkOutput(name, done_cnt - d0, 1);
        checkOutput({name, "_busy"}, busy, 0);
    endtask

    initial begin
        int k;
        int d0;
        int e0;

        repeat (3) @(negedge clock);
        checkOutput("reset_drive", line_drive_low, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", frame_done, 0);
        checkOutput("reset_err", bus_error, 0);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        $display("[TB] nominal frame");
        applyStimulus(8'h37, 8'h00, 8'h19, 8'h05, 1200, 1'b1, 8'h55);
        waitDone("nominal_done");

        $display("[TB] short start then minimum start");
        d0 = drive_cnt;
        hostPulse(999);
        repeat (60) @(negedge clock);
        checkOutput("short_no_drive", drive_cnt - d0, 0);
        checkOutput("short_busy", busy, 0);
        applyStimulus(8'h37, 8'h00, 8'h19, 8'h05, 1000, 1'b1, 8'h55);
        waitDone("min_start_done");

        $display("[TB] checksum wrap");
        applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1200, 1'b1, 8'hFC);
        waitDone("wrap_done");

        $display("[TB] snapshot under input change");
        applyStimulus(8'hA5, 8'h3C, 8'h0F, 8'h81, 1200, 1'b1, 8'h71);
        k = 0;
        while (!(dst == 2 && dec_bits >= 10) && k < 3000) begin
            @(negedge clock);
            k++;
        end
        checkOutput("snapshot_reach_bit10", (dst == 2 && dec_bits >= 10), 1);
        hum_int  = 8'h00;
        hum_dec  = 8'h00;
        temp_int = 8'h00;
        temp_dec = 8'h00;
        waitDone("snapshot_done");

        $display("[TB] bus conflict in ACK_HIGH");
        applyStimulus(8'h37, 8'h00, 8'h19, 8'h05, 1200, 1'b0, 8'h00);
        k = 0;
        while (!line_drive_low && k < 200) begin
            @(negedge clock);
            k++;
        end
        k = 0;
        while (line_drive_low && k < 200) begin
            @(negedge clock);
            k++;
        end
        repeat (20) @(negedge clock);
        e0 = err_cnt;
        host_low = 1'b1;
        k = 0;
        while (err_cnt == e0 && k < 10) begin
            @(negedge clock);
            k++;
        end
        checkOutput("conflict_error", err_cnt - e0, 1);
        checkOutput("conflict_release", line_drive_low, 0);
        checkOutput("conflict_busy", busy, 0);
        repeat (2) @(negedge clock);
        host_low = 1'b0;
        repeat (50) @(negedge clock);
        checkOutput("conflict_single_pulse", err_cnt - e0, 1);
        applyStimulus(8'h37, 8'h00, 8'h19, 8'h05, 1200, 1'b1, 8'h55);
        waitDone("after_conflict_done");

        $display("[TB] reset during BIT_LOW");
        applyStimulus(8'h37, 8'h00, 8'h19, 8'h05, 1200, 1'b0, 8'h00);
        k = 0;
        while (!(dst == 2 && dec_bits >= 3 && line_drive_low) && k < 3000) begin
            @(negedge clock);
            k++;
        end
        checkOutput("reach_bit_low", line_drive_low, 1);
        d0 = done_cnt;
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("reset_mid_release", line_drive_low, 0);
        checkOutput("reset_mid_busy", busy, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (300) @(negedge clock);
        checkOutput("reset_mid_no_done", done_cnt - d0, 0);

`ifdef SENSOR_FAULT_INJECT_EN
        $display("[TB] checksum fault injection");
        fault_inject = 1'b1;
        applyStimulus(8'h37, 8'h00, 8'h19, 8'h05, 1200, 1'b1, 8'h54);
        fault_inject = 1'b0;
        waitDone("fault_done");
`endif

        repeat (20) @(negedge clock);
        checkOutput("frames_scored", rd_ptr, exp_q.size());
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
